// File: rtl/vga_if.sv
// vga_if: raster position, frame tick and DAC pin bundle from the timing generator
interface vga_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       o_frame_over;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    modport master (
        output pixel_x, pixel_y, video_on, o_frame_over,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );
    modport slave (
        input pixel_x, pixel_y, video_on, o_frame_over,
        input VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );
endinterface

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: raster counters, frame tick and delay-matched DAC sync/blank pins
module vga_timing_generator #(
    parameter int   H_VIS      = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_VIS      = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   SYNC_DELAY = 3
) (
    input logic   pixel_clk,
    input logic   rst,
    vga_if.master vga
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FO = 10'(V_VIS);
    localparam logic [10:0] HV = 11'(H_VIS);
    localparam logic [10:0] HS0 = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS1 = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VV = 11'(V_VIS);
    localparam logic [10:0] VS0 = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS1 = 11'(V_VIS + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_generator: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_generator: SYNC_DELAY must be 0..7");
    end

    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        frame_over_q, frame_over_d;
    logic        h_wrap, video_on, hs_raw, vs_raw;
    logic [10:0] hx, vy;
    logic [2:0]  raw, pins;

    always_comb begin
        h_wrap = h_cnt_q == H_LAST;
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
        v_cnt_d = !h_wrap ? v_cnt_q : (v_cnt_q == V_LAST ? '0 : v_cnt_q + 10'd1);
        frame_over_d = h_cnt_d == '0 && v_cnt_d == V_FO;
        hx = {1'b0, h_cnt_q};
        vy = {1'b0, v_cnt_q};
        video_on = hx < HV && vy < VV;
        hs_raw = hx >= HS0 && hx < HS1;
        vs_raw = vy >= VS0 && vy < VS1;
        raw = {hs_raw, vs_raw, video_on};
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            frame_over_q <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            frame_over_q <= frame_over_d;
        end
    end

    // All-zero stages mean sync deasserted and blanked, so reset flushes the line inactive
    if (SYNC_DELAY == 0) begin : g_no_delay
        assign pins = raw;
    end else begin : g_delay
        logic [SYNC_DELAY-1:0][2:0] dly_q, dly_d;
        always_comb begin
            dly_d[0] = raw;
            for (int i = 1; i < SYNC_DELAY; i++) dly_d[i] = dly_q[i-1];
        end
        always_ff @(posedge pixel_clk) begin
            if (rst) dly_q <= '0;
            else dly_q <= dly_d;
        end
        assign pins = dly_q[SYNC_DELAY-1];
    end

    assign vga.pixel_x = h_cnt_q;
    assign vga.pixel_y = v_cnt_q;
    assign vga.video_on = video_on;
    assign vga.o_frame_over = frame_over_q;
    assign vga.VGA_HS = pins[2] ? HS_POL : !HS_POL;
    assign vga.VGA_VS = pins[1] ? VS_POL : !VS_POL;
    assign vga.VGA_BLANK_N = pins[0];
    assign vga.VGA_SYNC_N = 1'b0;
endmodule
